// File: rtl/divider_8bit_ctrl_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
// Holds the FSM state encoding, default operand/counter widths and the
// quotient value reported when the divisor is zero.
package divider_8bit_ctrl_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  // Quotient reported for a division by zero (all ones).
  localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_CHK = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/subtractor_8bit.sv
// 8-bit ripple subtractor: diff = a - b, computed as a + ~b + carry_i.
// Latency: combinational. Backpressure: none.
// Ports: a_i/b_i operands, carry_i = 1 for a plain subtract,
//        diff_o result, carry_o = 1 when no borrow occurred (a >= b).
module subtractor_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       carry_i,
  output logic [7:0] diff_o,
  output logic       carry_o
);

  assign {carry_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {8'b0, carry_i};

endmodule

// File: rtl/divider_8bit_ctrl.sv
// Multi-cycle unsigned 8-bit restoring divider, one trial subtraction per clock.
// Latency: done pulses 10 cycles after an accepted start (2 for divide by zero).
// Backpressure: start is only sampled in IDLE; busy is high in LOAD_CHK/RUN.
// Ports: clk, reset (sync, active-high), start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
//        Results are held until the next accepted start completes.
module divider_8bit_ctrl
  import divider_8bit_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if (WIDTH != 8) begin : g_bad_width
    $error("divider_8bit_ctrl: only WIDTH = 8 is supported");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("divider_8bit_ctrl: CNT_W too narrow to count WIDTH steps");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_q, d_d;      // captured divisor
  logic [WIDTH-1:0] r_q, r_d;      // partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;  // internal flag, published only in DONE
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  // Trial value: partial remainder with the next dividend bit shifted in.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_no_borrow;
  logic             step_ok;

  assign trial = {r_q, q_q[WIDTH-1]};

  subtractor_8bit u_sub (
    .a_i     (trial[WIDTH-1:0]),
    .b_i     (d_q),
    .carry_i (1'b1),
    .diff_o  (sub_diff),
    .carry_o (sub_no_borrow)
  );

  // A set ninth bit means trial > 255 >= D, so the subtraction always fits;
  // the low 8 bits of the wrapped difference are then the correct remainder.
  assign step_ok = trial[WIDTH] | sub_no_borrow;

  always_comb begin
    state_d       = state_q;
    q_d           = q_q;
    d_d           = d_q;
    r_d           = r_q;
    cnt_d         = cnt_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = LOAD_CHK;
        end
      end
      LOAD_CHK: begin
        if (d_q == '0) begin
          // Remainder takes the untouched dividend still sitting in Q.
          r_d     = q_q;
          q_d     = DBZ_QUOTIENT;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          dbz_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], step_ok};
        r_d   = step_ok ? sub_diff : trial[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        quotient_d    = q_q;
        remainder_d   = r_q;
        div_by_zero_d = dbz_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      q_q           <= '0;
      d_q           <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      d_q           <= d_d;
      r_q           <= r_d;
      cnt_q         <= cnt_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q == LOAD_CHK) || (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_8bit_ctrl.sv
// Directed bench for divider_8bit_ctrl with a randomized operand sweep.
module tb_divider_8bit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider_8bit_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One division: start pulsed at edge N, then wait (bounded) for done.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_q, input logic [7:0] exp_r,
                         input logic exp_z, input int exp_lat);
    int         lat;
    int         busy_cnt;
    logic       seen;
    logic [7:0] held_q;
    held_q = quotient;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat      = 0;
    seen     = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        if (busy) busy_cnt++;
        if (i == 2) chk8({tag, " held"}, quotient, held_q);
      end
    end
    chki({tag, " latency"}, lat, exp_lat);
    chki({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    chk8({tag, " quotient"}, quotient, exp_q);
    chk8({tag, " remainder"}, remainder, exp_r);
    chk1({tag, " div_by_zero"}, div_by_zero, exp_z);
    @(posedge clk);
    #1;
    chk1({tag, " done_width"}, done, 1'b0);
  endtask

  initial begin
    int         dcount;
    int         pulse_idx[4];
    logic [7:0] cap_q;
    logic [7:0] cap_r;
    logic [7:0] ra;
    logic [7:0] rb;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk8("rst quotient", quotient, 8'h00);
    chk8("rst remainder", remainder, 8'h00);
    chk1("rst dbz", div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Basic divides and boundaries.
    run_div("200/7", 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 10);
    run_div("255/1", 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 10);
    run_div("255/255", 8'd255, 8'd255, 8'h01, 8'h00, 1'b0, 10);
    run_div("5/9", 8'd5, 8'd9, 8'h00, 8'h05, 1'b0, 10);
    run_div("100/0", 8'd100, 8'd0, 8'hFF, 8'h64, 1'b1, 2);
    run_div("130/3", 8'd130, 8'd3, 8'h2B, 8'h01, 1'b0, 10);

    // Start and operand changes during RUN are ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start  = 1'b0;
    dcount = 0;
    cap_q  = 8'h00;
    cap_r  = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 4) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        cap_q = quotient;
        cap_r = remainder;
      end
    end
    chki("ignore done_count", dcount, 1);
    chk8("ignore quotient", cap_q, 8'h1C);
    chk8("ignore remainder", cap_r, 8'h04);

    // Reset in the 4th RUN cycle aborts the division.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", done, 1'b0);
    chk8("abort quotient", quotient, 8'h00);
    chk8("abort remainder", remainder, 8'h00);
    chk1("abort dbz", div_by_zero, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    chki("abort quiet", dcount, 0);
    run_div("81/9", 8'd81, 8'd9, 8'h09, 8'h00, 1'b0, 10);

    // Start held for 30 cycles re-triggers every 11 cycles.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd128;
    divisor  = 8'd2;
    dcount   = 0;
    for (int k = 0; k < 4; k++) pulse_idx[k] = -1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 29) start = 1'b0;
      if (done) begin
        if (dcount < 4) pulse_idx[dcount] = i;
        dcount++;
        chk8("held quotient", quotient, 8'd64);
        chk8("held remainder", remainder, 8'd0);
      end
    end
    chki("held pulse_count", dcount, 3);
    chki("held pulse0", pulse_idx[0], 10);
    chki("held pulse1", pulse_idx[1], 21);
    chki("held pulse2", pulse_idx[2], 32);

    // Random sweep against a reference computed here.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (n % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (rb == 8'd0) begin
        run_div("rand", ra, rb, 8'hFF, ra, 1'b1, 2);
      end else begin
        run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 10);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_8bit_ctrl.md
Name: divider_8bit_ctrl

Overview:
Multi-cycle unsigned 8-bit restoring divider. An FSM sequences one trial subtraction per clock through an 8-bit subtractor datapath. It sits beside the lab's adder/subtractor blocks as the first sequential consumer of the subtractor, with a start/busy/done handshake toward the host logic.

Parameters:
WIDTH, 8, operand width; only 8 is supported and checked at elaboration.
CNT_W, 4, width of the iteration counter; must hold the value WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a division; sampled only in IDLE.
dividend  input  8  unsigned dividend; captured on the accepted start.
divisor  input  8  unsigned divisor; captured on the accepted start.
busy  output  1  high while in LOAD_CHK or RUN.
done  output  1  one-cycle pulse when results become valid.
quotient  output  8  unsigned quotient; held until the next accepted start.
remainder  output  8  unsigned remainder; held until the next accepted start.
div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset mid-operation aborts the division. The next cycle is IDLE with all outputs at their reset values.
- FSM states: IDLE, LOAD_CHK, RUN, DONE.
- IDLE:
  - start=1 captures dividend into shift register Q and divisor into D, clears R (8b) and the counter, and goes to LOAD_CHK.
  - start=0 stays in IDLE.
  - Outputs hold their last results.
- LOAD_CHK:
  - D==0: quotient=8'hFF, remainder=captured dividend, div_by_zero=1, go to DONE.
  - Otherwise div_by_zero=0, go to RUN.
- RUN, one step per cycle, exactly WIDTH cycles:
  - T = {R, Q[7]} (9 bits). Q shifts left by 1.
  - If T >= {1'b0, D}: R = T - D (low 8 bits) and Q[0]=1. Otherwise R = T[7:0] and Q[0]=0.
  - Compare rule: T[8]=1 always succeeds. Otherwise success is no borrow from the 8-bit subtractor on T[7:0] - D.
  - Counter increments each step. After step WIDTH, go to DONE.
- DONE: quotient=Q, remainder=R, done=1 for this one cycle, then unconditionally IDLE.
- Latency, start high at edge N:
  - Normal divide: done high in the cycle after edge N+10 (LOAD_CHK at N+1, RUN N+2..N+9, DONE at N+10).
  - Divide by zero: done high in the cycle after edge N+2.
- Input rules:
  - start is ignored when not in IDLE. Operand changes after capture have no effect.
  - start asserted in the DONE cycle is ignored. start high in the following IDLE cycle is accepted (back-to-back spacing is 1 idle cycle).
  - start held continuously re-triggers a new division every 11 cycles.
- Result timing: quotient/remainder/div_by_zero update only in DONE (or on reset), never mid-computation.
- Invariant when div_by_zero=0: dividend = quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, LOAD_CHK=2'd1, RUN=2'd2, DONE=2'd3), the WIDTH default, and the div-by-zero quotient constant 8'hFF.
- One sub-module is natural: instantiate the team's subtractor_8bit for R_shifted - D.
  - carry_in tied per its borrow convention.
  - carry_out decoded to the borrow/success flag.
  - The controller owns all registers and the FSM.

Test Plan:
- reset; start with dividend=200, divisor=7 -> done after 10 cycles; quotient=8'h1C (28), remainder=8'h04, div_by_zero=0; busy high for exactly 9 cycles.
- dividend=255, divisor=1 -> quotient=8'hFF, remainder=0; dividend=255, divisor=255 -> quotient=1, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=100, divisor=0 -> done 2 cycles after start; quotient=8'hFF, remainder=8'h64, div_by_zero=1; the next valid divide clears div_by_zero.
- start pulsed and operands changed to 50/3 during RUN of 200/7 -> ignored; result 28 r4; done pulses exactly once.
- reset asserted in the 4th RUN cycle -> next cycle IDLE, all outputs 0, no done; a following start 81/9 -> quotient=9, remainder=0.
- start held high for 30 cycles with 128/2 -> done pulses at 11-cycle spacing, each with quotient=64, remainder=0; random 1000-pair sweep checks the invariant.
